// File: rtl/br_write_arbiter.sv
// Round-robin writeback arbiter for the register-file write port: ALU (A) vs load (M).
// Optional write-stage bypass outputs are enabled with `define BR_WB_BYPASS_EN.
module br_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              m_valid,
    output logic              m_ready,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_data,
    output logic [ADDR_W-1:0] adrsWrite,
    output logic              RegEn,
    output logic [DATA_W-1:0] write,
    output logic [CNT_W-1:0]  conflict_cnt
`ifdef BR_WB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0] adrsReadA,
    input  logic [ADDR_W-1:0] adrsReadB,
    output logic              fwdA_hit,
    output logic              fwdB_hit,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    logic              rr_ptr_q, rr_ptr_d;
    logic              reg_en_q, reg_en_d;
    logic [ADDR_W-1:0] adrs_q, adrs_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              a_grant_s, m_grant_s;
    logic              xfer_a_s, xfer_m_s;

    // Grant selection: a ready depends only on valids, hold and the round-robin pointer
    always_comb begin
        a_grant_s = 1'b0;
        m_grant_s = 1'b0;
        if (hold) begin
            a_grant_s = 1'b0;
            m_grant_s = 1'b0;
        end else if (a_valid && m_valid) begin
            a_grant_s = ~rr_ptr_q;
            m_grant_s = rr_ptr_q;
        end else if (a_valid) begin
            a_grant_s = 1'b1;
        end else if (m_valid) begin
            m_grant_s = 1'b1;
        end else begin
            a_grant_s = 1'b0;
            m_grant_s = 1'b0;
        end
    end

    assign a_ready  = a_grant_s;
    assign m_ready  = m_grant_s;
    assign xfer_a_s = a_valid & a_grant_s;
    assign xfer_m_s = m_valid & m_grant_s;

    // Next-state for pointer, output stage and conflict counter
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        reg_en_d = 1'b0;
        adrs_d   = adrs_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        if (xfer_a_s) begin
            rr_ptr_d = 1'b1;
            // Writes to $zero are accepted but never reach the register file
            if (a_addr != {ADDR_W{1'b0}}) begin
                reg_en_d = 1'b1;
                adrs_d   = a_addr;
                data_d   = a_data;
            end else begin
                reg_en_d = 1'b0;
            end
        end else if (xfer_m_s) begin
            rr_ptr_d = 1'b0;
            if (m_addr != {ADDR_W{1'b0}}) begin
                reg_en_d = 1'b1;
                adrs_d   = m_addr;
                data_d   = m_data;
            end else begin
                reg_en_d = 1'b0;
            end
        end else begin
            reg_en_d = 1'b0;
        end
        if (a_valid && m_valid && !hold && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= 1'b0;
            reg_en_q <= 1'b0;
            adrs_q   <= {ADDR_W{1'b0}};
            data_q   <= {DATA_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            rr_ptr_q <= rr_ptr_d;
            reg_en_q <= reg_en_d;
            adrs_q   <= adrs_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
        end
    end

    assign adrsWrite    = adrs_q;
    assign RegEn        = reg_en_q;
    assign write        = data_q;
    assign conflict_cnt = cnt_q;

`ifdef BR_WB_BYPASS_EN
    assign fwdA_hit = reg_en_q && (adrs_q == adrsReadA) && (adrsReadA != {ADDR_W{1'b0}});
    assign fwdB_hit = reg_en_q && (adrs_q == adrsReadB) && (adrsReadB != {ADDR_W{1'b0}});
    assign fwd_data = data_q;
`endif

endmodule
